// File: rtl/model_nexys_hls4ml_prj_1_mac_pkg.sv
// Shared types and constants for the pipelined signed MAC and its rescale/narrow stage.
package model_nexys_hls4ml_prj_1_mac_pkg;

  localparam int unsigned A_W_DEF = 11;
  localparam int unsigned B_W_DEF = 16;
  localparam int unsigned PROD_W  = A_W_DEF + B_W_DEF;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  typedef struct packed {
    logic valid;
    logic mode;
    logic first;
    logic last;
  } stage_tag_t;

  // A beat produces an output in multiply mode always, in accumulate mode only on the last term.
  function automatic logic tag_emits(stage_tag_t t);
    return t.valid && ((t.mode == MODE_MUL) || t.last);
  endfunction

  function automatic logic tag_accum(stage_tag_t t);
    return t.valid && (t.mode == MODE_ACC);
  endfunction

endpackage

// File: rtl/model_nexys_hls4ml_prj_1_round_sat.sv
// Combinational round-half-up rescale followed by saturating or wrapping narrowing.
module model_nexys_hls4ml_prj_1_round_sat #(
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned DOUT_W     = 24,
  parameter int          FRAC_SHIFT = 0,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DOUT_W-1:0] dout_o,
  output logic              sat_o
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int unsigned EW = ACC_W + 1;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shf;

  assign ext = {acc_i[ACC_W-1], acc_i};

  if (FRAC_SHIFT > 0) begin : g_round
    localparam logic signed [EW-1:0] Half = EW'(1) <<< (FRAC_SHIFT - 1);
    logic signed [EW-1:0] rnd;
    assign rnd = ext + Half;
    assign shf = rnd >>> FRAC_SHIFT;
  end else begin : g_pass
    assign shf = ext;
  end

  if (SATURATE) begin : g_sat
    logic in_range;
    // In range iff every bit from the guard bit down to the output sign bit agrees.
    assign in_range = (&shf[EW-1:DOUT_W-1]) | ~(|shf[EW-1:DOUT_W-1]);

    always_comb begin
      dout_o = shf[DOUT_W-1:0];
      sat_o  = 1'b0;
      if (!in_range) begin
        sat_o  = 1'b1;
        dout_o = shf[EW-1] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
      end
    end
  end else begin : g_wrap
    assign dout_o = shf[DOUT_W-1:0];
    assign sat_o  = 1'b0;
  end

endmodule

// File: rtl/model_nexys_hls4ml_prj_1_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with valid/ready flow control, clock
// enable, round-half-up rescaling and optional saturation.
module model_nexys_hls4ml_prj_1_mac_pipe
  import model_nexys_hls4ml_prj_1_mac_pkg::*;
#(
  parameter int unsigned A_W        = A_W_DEF,
  parameter int unsigned B_W        = B_W_DEF,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned DOUT_W     = 24,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int          FRAC_SHIFT = 0,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    din0,
  input  logic [B_W-1:0]    din1,
  input  logic              acc_mode,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              out_sat
);

  localparam int unsigned ProdW = A_W + B_W;
  // Product-carrying stages between the operand register and the output stage.
  localparam int unsigned NumP  = NUM_STAGE - 2;

  logic advance;

  logic signed [A_W-1:0] a_q;
  logic signed [B_W-1:0] b_q;
  stage_tag_t            s1_tag_q;

  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] p_q   [NumP];
  stage_tag_t              ptag_q[NumP];

  stage_tag_t              fin_tag;
  logic signed [ProdW-1:0] fin_p;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] result;
  logic signed [ACC_W-1:0] acc_q;

  logic [DOUT_W-1:0] rs_dout;
  logic              rs_sat;
  logic              out_valid_q;
  logic [DOUT_W-1:0] dout_q;
  logic              sat_q;

  // The whole pipeline stalls together: a held output blocks every stage and the input.
  assign advance  = ce & ~(out_valid_q & ~out_ready);
  assign in_ready = advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      s1_tag_q <= '0;
    end else if (advance) begin
      s1_tag_q <= '{valid: in_valid, mode: acc_mode, first: in_first, last: in_last};
      if (in_valid) begin
        a_q <= din0;
        b_q <= din1;
      end
    end
  end

  assign prod = ProdW'(a_q) * ProdW'(b_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NumP; i++) begin
        p_q[i]    <= '0;
        ptag_q[i] <= '0;
      end
    end else if (advance) begin
      p_q[0]    <= prod;
      ptag_q[0] <= s1_tag_q;
      for (int i = 1; i < NumP; i++) begin
        p_q[i]    <= p_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
    end
  end

  assign fin_tag = ptag_q[NumP-1];
  assign fin_p   = p_q[NumP-1];

  always_comb begin
    p_ext   = ACC_W'(fin_p);
    acc_sum = fin_tag.first ? p_ext : acc_q + p_ext;
    result  = (fin_tag.mode == MODE_ACC) ? acc_sum : p_ext;
  end

  model_nexys_hls4ml_prj_1_round_sat #(
    .ACC_W      (ACC_W),
    .DOUT_W     (DOUT_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .acc_i  (result),
    .dout_o (rs_dout),
    .sat_o  (rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
    end else if (advance) begin
      out_valid_q <= tag_emits(fin_tag);
      if (tag_emits(fin_tag)) begin
        dout_q <= rs_dout;
        sat_q  <= rs_sat;
      end
      // Multiply-mode beats pass by without disturbing a running sum.
      if (tag_accum(fin_tag)) begin
        acc_q <= acc_sum;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_sat   = sat_q;

endmodule

// File: doc/model_nexys_hls4ml_prj_1_mac_pipe.md
Name: model_nexys_hls4ml_prj_1_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the fixed-width 11s×16s→24 DSP multiplier used by the generated layer datapaths. It adds a runtime multiply/accumulate mode, valid/ready flow control with backpressure, round-half-up fixed-point rescaling and optional saturation. It sits between the weight/activation streamers and the layer output buffers.

Parameters:
A_W, 11, signed width of din0
B_W, 16, signed width of din1
ACC_W, 40, accumulator width; must be ≥ A_W+B_W
DOUT_W, 24, signed output width
NUM_STAGE, 3, latency in advancing cycles from accepted input to out_valid; legal range ≥3
FRAC_SHIFT, 0, arithmetic right shift applied to the result before narrowing; 0 means no shift
SATURATE, 1, 1 clamps to the DOUT_W range; 0 truncates (two's-complement wrap)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
ce  in  1  global clock enable; when 0 the whole pipeline freezes
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
din0  in  A_W  signed operand a
din1  in  B_W  signed operand b
acc_mode  in  1  0 = multiply only, 1 = accumulate; sampled with every beat
in_first  in  1  accumulate mode: start a new sum with this product
in_last  in  1  accumulate mode: emit the sum after this product
out_valid  out  1  dout valid
out_ready  in  1  downstream accepts when out_valid && out_ready
dout  out  DOUT_W  signed result
out_sat  out  1  1 when the current dout was clamped; qualified by out_valid

Behaviour:
- Reset (reset=0, async assert, sync-release by the clk domain): out_valid=0, dout=0, out_sat=0, accumulator=0, all stage valid bits=0. Data registers are cleared too. A partial sum in flight is discarded.
- advance = ce && !(out_valid && !out_ready). in_ready = advance (combinational). All stage registers, including the valid bits, update only when advance=1. When advance=0, dout, out_valid and out_sat hold their values.
- Pipeline structure:
  - Stage 1 registers din0, din1, acc_mode, in_first, in_last and valid.
  - Stages 2..NUM_STAGE-1 carry the full-precision product P = a*b (width A_W+B_W) plus the tags.
  - Final stage computes the accumulator and the rescaled output.
- Multiply mode (tag acc_mode=0):
  - Result R = sign-extend(P) to ACC_W.
  - out_valid is asserted for every beat, NUM_STAGE advancing cycles after acceptance.
  - The accumulator is not modified.
- Accumulate mode (tag acc_mode=1):
  - acc_next = in_first ? P : acc + P, computed in ACC_W with modulo wrap and no overflow flag.
  - Output is produced only on the beat with in_last=1, with R = acc_next. Other beats produce no out_valid.
  - in_first && in_last together gives a single-term sum, R = P.
  - in_last without a preceding in_first continues from the current accumulator (0 after reset).
- Rescale:
  - If FRAC_SHIFT>0: R' = (R + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. Rounding is half toward +inf.
  - Otherwise R' = R.
- Narrowing:
  - SATURATE=1: clamp R' to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; out_sat=1 iff a clamp occurred.
  - SATURATE=0: dout = R'[DOUT_W-1:0]; out_sat=0.
- Mode can change beat to beat. A multiply-mode beat in the middle of an accumulation leaves the accumulator intact.
- Throughput is 1 beat/cycle with out_ready=1 and ce=1. No bubbles are inserted.
- A beat that is not accepted leaves no trace.

Decomposition:
- Shared package model_nexys_hls4ml_prj_1_mac_pkg:
  - localparams PROD_W = A_W+B_W
  - mode encoding constants MODE_MUL=0 and MODE_ACC=1
  - a stage-tag struct {valid, mode, first, last}
- One sub-module: model_nexys_hls4ml_prj_1_round_sat. It is purely combinational, ACC_W in → DOUT_W out plus a sat flag, parametrised by FRAC_SHIFT and SATURATE, and is instantiated in the final stage.

Test Plan:
1. Multiply mode, defaults: beat a=-3, b=1000 → dout=-3000, out_sat=0, out_valid exactly 3 cycles after acceptance. Back-to-back beats give outputs on consecutive cycles.
2. Saturation: a=-1024, b=-32768 (P=33554432) → dout=8388607, out_sat=1. With a=-1024, b=32767 → dout=-8388608, out_sat=1.
3. Accumulate: beats (2,3,first), (4,5), (-1,6,last) → exactly one out_valid, with dout=20. A multiply beat (7,7) inserted mid-sum → dout=49 for that beat, and the sum is still 20.
4. Backpressure: stream 8 beats with out_ready=0 for 4 cycles once out_valid rises → in_ready=0 throughout, dout stable, no loss or duplication, and all 8 results arrive in order.
5. FRAC_SHIFT=4: (1,24) → dout=2; (-1,24) → dout=-1; (1,8) → dout=1.
6. Reset mid-accumulation after (5,5,first): assert reset for 2 cycles → out_valid=0 and dout=0 immediately. A following (1,1,last) without first → dout=1. ce=0 for 3 cycles freezes all state.
